// File: rtl/tlb_refill_walker_pkg.sv
// Shared definitions for the TLB refill walker: address geometry, PTE field
// positions, walker state encodings and the walk counter width.
package tlb_refill_walker_pkg;

   // Address geometry. PAGE_SIZE is the page-offset width in bits.
   localparam int VIRT_ADDR_WIDTH    = 32;
   localparam int PAGE_SIZE          = 12;
   localparam int PHY_PAGE_NUM_WIDTH = 8;

   // PTE layout: bit 31 marks a valid mapping, PPN sits in the low bits.
   localparam int PTE_VALID_BIT = 31;
   localparam int PTE_PPN_LSB   = 0;

   // Width of the saturating completed-walk counter.
   localparam int WALK_CNT_W = 16;

   typedef enum logic [1:0] {
      WS_IDLE = 2'd0,
      WS_WALK = 2'd1,
      WS_RESP = 2'd2,
      WS_HOLD = 2'd3
   } walk_state_e;

endpackage

// File: rtl/tlb_walk_arb.sv
// Two-way round-robin arbiter between the iTLB and dTLB miss requests.
// Grant is combinational; the last-served flag moves only when the walker
// accepts the grant, and resets to the D side so the iTLB wins the first tie.
module tlb_walk_arb (
   input  logic clk,
   input  logic reset,
   input  logic itlb_req_i,
   input  logic dtlb_req_i,
   input  logic accept_i,
   output logic gnt_valid_o,
   output logic gnt_is_d_o
);

   logic last_d_q;
   logic last_d_d;

   // Pick a requester: a lone request wins, a tie goes to the side not served last.
   always_comb begin
      // NOTE: every output gets a value on every path, so no latch is inferred.
      gnt_valid_o = itlb_req_i | dtlb_req_i;
      gnt_is_d_o  = dtlb_req_i;
      if (itlb_req_i && dtlb_req_i) begin
         gnt_is_d_o = ~last_d_q;
      end
      last_d_d = accept_i ? gnt_is_d_o : last_d_q;
   end

   // Remember which side was served last.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         last_d_q <= 1'b1;
      end else begin
         last_d_q <= last_d_d;
      end
   end

endmodule

// File: rtl/tlb_refill_walker.sv
// Page-table walker servicing iTLB/dTLB misses. A granted miss fetches its
// PTE from pt_base + 4*VPN, then either refills the requesting TLB or raises
// a page fault. Every output is registered; the FSM spends one HOLD cycle
// after each response so the TLB's registered miss can drop.
module tlb_refill_walker
   import tlb_refill_walker_pkg::*;
#(
   parameter int VPN_W   = VIRT_ADDR_WIDTH - PAGE_SIZE,
   parameter int PPN_W   = PHY_PAGE_NUM_WIDTH,
   parameter int PADDR_W = 20,
   parameter int PTE_W   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  itlb_miss,
   input  logic [VPN_W-1:0]      itlb_vpn,
   output logic                  itlb_write,
   output logic [PPN_W-1:0]      itlb_ppn,
   input  logic                  dtlb_miss,
   input  logic [VPN_W-1:0]      dtlb_vpn,
   output logic                  dtlb_write,
   output logic [PPN_W-1:0]      dtlb_ppn,
   input  logic [PADDR_W-1:0]    pt_base,
   output logic                  mem_req,
   output logic [PADDR_W-1:0]    mem_addr,
   input  logic                  mem_ack,
   input  logic [PTE_W-1:0]      mem_rdata,
   output logic                  fault,
   output logic [VPN_W-1:0]      fault_vpn,
   output logic                  fault_is_d,
   output logic                  busy,
   output logic [WALK_CNT_W-1:0] walk_count
);

   walk_state_e state_q, state_d;

   logic gnt_valid;
   logic gnt_is_d;
   logic grant;
   logic walk_done;
   logic pte_valid;
   logic [VPN_W-1:0] gnt_vpn;
   logic [PPN_W-1:0] pte_ppn;

   logic                  side_q, side_d;
   logic [VPN_W-1:0]      vpn_q, vpn_d;
   logic                  mem_req_q, mem_req_d;
   logic [PADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic                  itlb_write_q, itlb_write_d;
   logic                  dtlb_write_q, dtlb_write_d;
   logic [PPN_W-1:0]      itlb_ppn_q, itlb_ppn_d;
   logic [PPN_W-1:0]      dtlb_ppn_q, dtlb_ppn_d;
   logic                  fault_q, fault_d;
   logic [VPN_W-1:0]      fault_vpn_q, fault_vpn_d;
   logic                  fault_is_d_q, fault_is_d_d;
   logic                  busy_q, busy_d;
   logic [WALK_CNT_W-1:0] walk_count_q, walk_count_d;

   // Only the valid bit and PPN field of the PTE are consumed.
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;

   tlb_walk_arb u_arb (
      .clk         (clk),
      .reset       (reset),
      .itlb_req_i  (itlb_miss),
      .dtlb_req_i  (dtlb_miss),
      .accept_i    (grant),
      .gnt_valid_o (gnt_valid),
      .gnt_is_d_o  (gnt_is_d)
   );

   assign grant     = (state_q == WS_IDLE) && gnt_valid;
   assign walk_done = (state_q == WS_WALK) && mem_ack;
   assign gnt_vpn   = gnt_is_d ? dtlb_vpn : itlb_vpn;
   assign pte_valid = mem_rdata[PTE_VALID_BIT];
   assign pte_ppn   = mem_rdata[PTE_PPN_LSB +: PPN_W];

   // State register; reset abandons any walk in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: grant, wait for the PTE, respond once, hold once.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WS_IDLE: if (gnt_valid) state_d = WS_WALK;
         WS_WALK: if (mem_ack)   state_d = WS_RESP;
         WS_RESP: state_d = WS_HOLD;
         WS_HOLD: state_d = WS_IDLE;
         default: state_d = WS_IDLE;
      endcase
   end

   // Output logic: next values of every registered output and walk context.
   always_comb begin
      mem_req_d    = (state_d == WS_WALK);
      busy_d       = (state_d != WS_IDLE);
      itlb_write_d = 1'b0;
      dtlb_write_d = 1'b0;
      fault_d      = 1'b0;
      itlb_ppn_d   = itlb_ppn_q;
      dtlb_ppn_d   = dtlb_ppn_q;
      fault_vpn_d  = fault_vpn_q;
      fault_is_d_d = fault_is_d_q;
      walk_count_d = walk_count_q;
      side_d       = side_q;
      vpn_d        = vpn_q;
      mem_addr_d   = mem_addr_q;

      // Capture the request at grant; the address is then frozen for the walk.
      if (grant) begin
         side_d     = gnt_is_d;
         vpn_d      = gnt_vpn;
         mem_addr_d = pt_base + PADDR_W'({gnt_vpn, 2'b00});
      end

      if (walk_done) begin
         if (pte_valid) begin
            if (side_q) begin
               dtlb_write_d = 1'b1;
               dtlb_ppn_d   = pte_ppn;
            end else begin
               itlb_write_d = 1'b1;
               itlb_ppn_d   = pte_ppn;
            end
         end else begin
            fault_d      = 1'b1;
            fault_vpn_d  = vpn_q;
            fault_is_d_d = side_q;
         end
         if (!(&walk_count_q)) begin
            walk_count_d = walk_count_q + WALK_CNT_W'(1);
         end
      end
   end

   // Output and walk-context registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         itlb_write_q <= 1'b0;
         dtlb_write_q <= 1'b0;
         itlb_ppn_q   <= '0;
         dtlb_ppn_q   <= '0;
         fault_q      <= 1'b0;
         fault_vpn_q  <= '0;
         fault_is_d_q <= 1'b0;
         busy_q       <= 1'b0;
         walk_count_q <= '0;
         side_q       <= 1'b0;
         vpn_q        <= '0;
      end else begin
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         itlb_write_q <= itlb_write_d;
         dtlb_write_q <= dtlb_write_d;
         itlb_ppn_q   <= itlb_ppn_d;
         dtlb_ppn_q   <= dtlb_ppn_d;
         fault_q      <= fault_d;
         fault_vpn_q  <= fault_vpn_d;
         fault_is_d_q <= fault_is_d_d;
         busy_q       <= busy_d;
         walk_count_q <= walk_count_d;
         side_q       <= side_d;
         vpn_q        <= vpn_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign itlb_write = itlb_write_q;
   assign dtlb_write = dtlb_write_q;
   assign itlb_ppn   = itlb_ppn_q;
   assign dtlb_ppn   = dtlb_ppn_q;
   assign fault      = fault_q;
   assign fault_vpn  = fault_vpn_q;
   assign fault_is_d = fault_is_d_q;
   assign busy       = busy_q;
   assign walk_count = walk_count_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_tlb_refill_walker;

   logic        clk;
   logic        reset;
   logic        itlb_miss;
   logic [19:0] itlb_vpn;
   logic        itlb_write;
   logic [7:0]  itlb_ppn;
   logic        dtlb_miss;
   logic [19:0] dtlb_vpn;
   logic        dtlb_write;
   logic [7:0]  dtlb_ppn;
   logic [19:0] pt_base;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        fault;
   logic [19:0] fault_vpn;
   logic        fault_is_d;
   logic        busy;
   logic [15:0] walk_count;

   int n_checks = 0;
   int n_fail   = 0;

   tlb_refill_walker dut (
      .clk        (clk),
      .reset      (reset),
      .itlb_miss  (itlb_miss),
      .itlb_vpn   (itlb_vpn),
      .itlb_write (itlb_write),
      .itlb_ppn   (itlb_ppn),
      .dtlb_miss  (dtlb_miss),
      .dtlb_vpn   (dtlb_vpn),
      .dtlb_write (dtlb_write),
      .dtlb_ppn   (dtlb_ppn),
      .pt_base    (pt_base),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .fault      (fault),
      .fault_vpn  (fault_vpn),
      .fault_is_d (fault_is_d),
      .busy       (busy),
      .walk_count (walk_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at a falling edge in IDLE with the miss already driven; the next
   // rising edge grants. Returns at the falling edge after the walker is back
   // in IDLE, so the caller can change the miss lines before the next grant.
   task automatic run_walk(input string tag, input logic exp_d, input logic [19:0] exp_vpn,
                           input logic [19:0] exp_addr, input int waits,
                           input logic [31:0] rdata, input logic [7:0] exp_ppn,
                           input logic exp_valid, input logic [15:0] exp_cnt);
      @(negedge clk);
      check({tag, " req"}, mem_req, 1);
      check({tag, " addr"}, mem_addr, exp_addr);
      check({tag, " busy"}, busy, 1);
      for (int k = 0; k < waits; k++) begin
         @(negedge clk);
         check({tag, " req held"}, mem_req, 1);
         check({tag, " addr held"}, mem_addr, exp_addr);
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check({tag, " req off"}, mem_req, 0);
      check({tag, " itlb_write"}, itlb_write, exp_valid && !exp_d);
      check({tag, " dtlb_write"}, dtlb_write, exp_valid && exp_d);
      check({tag, " fault"}, fault, !exp_valid);
      if (exp_valid) begin
         if (exp_d) check({tag, " dtlb_ppn"}, dtlb_ppn, exp_ppn);
         else       check({tag, " itlb_ppn"}, itlb_ppn, exp_ppn);
      end else begin
         check({tag, " fault_vpn"}, fault_vpn, exp_vpn);
         check({tag, " fault_is_d"}, fault_is_d, exp_d);
      end
      check({tag, " walk_count"}, walk_count, exp_cnt);
      @(negedge clk);
      check({tag, " hold itlb_write"}, itlb_write, 0);
      check({tag, " hold dtlb_write"}, dtlb_write, 0);
      check({tag, " hold fault"}, fault, 0);
      check({tag, " hold busy"}, busy, 1);
      @(negedge clk);
      check({tag, " idle busy"}, busy, 0);
   endtask

   initial begin
      reset     = 1'b1;
      itlb_miss = 1'b0;
      itlb_vpn  = 20'h0;
      dtlb_miss = 1'b0;
      dtlb_vpn  = 20'h0;
      pt_base   = 20'h10000;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;

      // Reset state
      do_reset();
      check("rst mem_req", mem_req, 0);
      check("rst busy", busy, 0);
      check("rst walk_count", walk_count, 0);
      check("rst fault", fault, 0);
      check("rst itlb_write", itlb_write, 0);
      check("rst dtlb_ppn", dtlb_ppn, 0);

      // iTLB refill, zero-wait ack: 0x10000 + 4*0x00111 = 0x10444
      itlb_miss = 1'b1;
      itlb_vpn  = 20'h00111;
      run_walk("irefill", 1'b0, 20'h00111, 20'h10444, 0, 32'h800000CD, 8'hCD, 1'b1, 16'd1);
      itlb_miss = 1'b0;
      check("irefill dtlb_ppn untouched", dtlb_ppn, 0);

      // dTLB fault after 5 wait cycles: 0x10000 + 4*0x0ABCD = 0x3AF34
      dtlb_miss = 1'b1;
      dtlb_vpn  = 20'h0ABCD;
      run_walk("dfault", 1'b1, 20'h0ABCD, 20'h3AF34, 5, 32'h000000CD, 8'h00, 1'b0, 16'd2);
      dtlb_miss = 1'b0;
      check("dfault dtlb_ppn untouched", dtlb_ppn, 0);
      check("dfault itlb_ppn kept", itlb_ppn, 8'hCD);

      // Tie from reset: iTLB first, then the re-raised tie goes to the dTLB
      do_reset();
      itlb_miss = 1'b1;
      itlb_vpn  = 20'h00001;
      dtlb_miss = 1'b1;
      dtlb_vpn  = 20'h00002;
      run_walk("tie1", 1'b0, 20'h00001, 20'h10004, 0, 32'h80000011, 8'h11, 1'b1, 16'd1);
      itlb_vpn = 20'h00003;
      run_walk("tie2", 1'b1, 20'h00002, 20'h10008, 1, 32'h80000022, 8'h22, 1'b1, 16'd2);
      dtlb_miss = 1'b0;

      // Address wrap: 0x00008 + 0x3FFFFC truncated to 20 bits = 0x00004
      itlb_vpn = 20'hFFFFF;
      pt_base  = 20'h00008;
      run_walk("wrap", 1'b0, 20'hFFFFF, 20'h00004, 0, 32'h00000000, 8'h00, 1'b0, 16'd3);
      itlb_miss = 1'b0;

      // Reset in the 3rd WALK cycle, ack one cycle later is discarded
      pt_base   = 20'h10000;
      dtlb_miss = 1'b1;
      dtlb_vpn  = 20'h00010;
      @(negedge clk);
      check("midrst walk1 req", mem_req, 1);
      @(negedge clk);
      @(negedge clk);
      check("midrst walk3 req", mem_req, 1);
      reset     = 1'b1;
      dtlb_miss = 1'b0;
      @(negedge clk);
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h800000EE;
      check("midrst mem_req", mem_req, 0);
      check("midrst busy", busy, 0);
      check("midrst walk_count", walk_count, 0);
      check("midrst fault_vpn", fault_vpn, 0);
      check("midrst itlb_ppn", itlb_ppn, 0);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check("late ack dtlb_write", dtlb_write, 0);
      check("late ack fault", fault, 0);
      check("late ack busy", busy, 0);
      check("late ack mem_req", mem_req, 0);
      check("late ack dtlb_ppn", dtlb_ppn, 0);
      check("late ack walk_count", walk_count, 0);

      // Saturation: preload the counter near the top, then walk past it
      force dut.walk_count_q = 16'hFFFE;
      #1;
      release dut.walk_count_q;
      check("sat preload", walk_count, 16'hFFFE);
      itlb_miss = 1'b1;
      itlb_vpn  = 20'h00111;
      run_walk("sat1", 1'b0, 20'h00111, 20'h10444, 0, 32'h800000CD, 8'hCD, 1'b1, 16'hFFFF);
      run_walk("sat2", 1'b0, 20'h00111, 20'h10444, 0, 32'h800000AB, 8'hAB, 1'b1, 16'hFFFF);
      itlb_miss = 1'b0;
      @(negedge clk);
      check("final idle busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_refill_walker.md
# tlb_refill_walker

Page-table walker that services TLB misses for the iTLB and dTLB. On a miss it fetches the 32-bit page-table entry (PTE) from memory and returns the physical page number through the TLB's refill port (`tlb_write` plus PPN). If the PTE is invalid, it raises a page fault instead. It sits between the two TLBs and the memory-side port, and is the responder to the TLB miss/refill interface.

## Interface
Parameters:
- VPN_W, 20, virtual page number width (`VIRT_ADDR_WIDTH - PAGE_SIZE`)
- PPN_W, 8, physical page number width (`PHY_PAGE_NUM_WIDTH`)
- PADDR_W, 20, physical address width on the memory port
- PTE_W, 32, memory read data width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- itlb_miss  in  1  level request; iTLB holds it high until refilled
- itlb_vpn  in  VPN_W  missing virtual page number from the iTLB
- itlb_write  out  1  one-cycle refill strobe to the iTLB
- itlb_ppn  out  PPN_W  refill translation; valid while itlb_write is high
- dtlb_miss, dtlb_vpn, dtlb_write, dtlb_ppn  same as the iTLB set, for the dTLB
- pt_base  in  PADDR_W  page-table base physical address; quasi-static
- mem_req  out  1  PTE read request
- mem_addr  out  PADDR_W  PTE address
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle
- mem_rdata  in  PTE_W  PTE word
- fault  out  1  one-cycle page-fault pulse
- fault_vpn  out  VPN_W  VPN of the last fault; held until the next fault
- fault_is_d  out  1  1 = last fault came from the dTLB side
- busy  out  1  high in every state except IDLE
- walk_count  out  16  completed walks (refills plus faults), saturating at 16'hFFFF

## Operation
- FSM states: IDLE, WALK, RESP, HOLD.
- IDLE:
  - If either miss input is high, grant one requester, latch its VPN and side, compute mem_addr, and go to WALK.
  - With both requests high, use round-robin: grant the side not served last. The last-served flag resets to D, so the iTLB wins the first tie.
- WALK:
  - mem_req = 1; mem_addr = (pt_base + {latched_vpn, 2'b00}) truncated to PADDR_W. Wrap-around is silent.
  - mem_addr is stable while mem_req is high.
  - On mem_ack, latch mem_rdata and go to RESP.
- RESP, for exactly one cycle:
  - If PTE[31] = 1, pulse the granted side's *_write with *_ppn = PTE[PPN_W-1:0].
  - Otherwise, pulse fault, load fault_vpn and fault_is_d, and leave both *_write low.
  - Increment walk_count unless it is saturated.
  - Go to HOLD.
- HOLD: one cycle with no grant, so the TLB's registered miss can drop. Then go to IDLE.
- Changes to a miss input or its VPN after the grant have no effect on the walk in progress.
- mem_ack outside WALK is ignored.
- reset, including mid-walk:
  - Next state is IDLE; the walk is abandoned.
  - mem_req, itlb_write, dtlb_write, fault, busy, walk_count, fault_vpn and fault_is_d all go to 0.
  - itlb_ppn and dtlb_ppn go to 0; last-served goes to D.
  - A late ack is discarded.

## Timing
- Miss sampled at edge N. mem_req is high from cycle N+1.
- mem_ack may arrive in the first WALK cycle (zero wait). The ack at edge M causes the write/fault pulse in cycle M+1, HOLD in M+2, and IDLE in M+3.
- Minimum miss-to-refill: miss seen at edge 0, write pulse in cycle 2. Back-to-back walks start every 4 cycles at minimum.
- All outputs are registered. The mem_ack to mem_req path is not combinational.

## Structure
- Shared header.vh adds:
  - PTE_VALID_BIT (31)
  - PTE_PPN_LSB (0)
  - walker state encodings WS_IDLE, WS_WALK, WS_RESP, WS_HOLD
  - WALK_CNT_W (16)
- It reuses VIRT_ADDR_WIDTH, PAGE_SIZE and PHY_PAGE_NUM_WIDTH.
- One sub-module, tlb_walk_arb: a 2-way round-robin arbiter with a last-served register. It is combinational grant logic plus an update-on-accept input.

## Test plan
- iTLB miss, VPN 20'h00111, pt_base 20'h10000, ack with 0 wait, rdata 32'h800000CD:
  - mem_addr = 20'h10444.
  - itlb_write pulses 1 cycle with itlb_ppn = 8'hCD two cycles after the miss.
  - dtlb_write stays 0; walk_count = 1.
- dTLB miss, ack after 5 wait cycles, rdata 32'h000000CD:
  - fault pulses once; fault_vpn = the requested VPN; fault_is_d = 1.
  - No *_write pulse.
- Both misses raised in the same cycle from reset: iTLB is served first, then dTLB. A second tie afterwards grants dTLB.
- reset asserted in the 3rd WALK cycle, then mem_ack arrives a cycle later:
  - mem_req is 0 after the reset edge, FSM is in IDLE, and no write or fault pulses.
  - walk_count = 0.
- VPN 20'hFFFFF with pt_base 20'h00008: mem_addr = 20'h00004 (wrap). 65536 forced walks leave walk_count at 16'hFFFF (saturated).
